// File: rtl/vector_pkg.sv
// rtl/vector_pkg.sv - shared Q8.24 constants, vector type and FSM states for vec3_normalize
package vector_pkg;

  localparam int VEC_W = 32;
  localparam int FRAC  = 24;

  localparam logic        [VEC_W-1:0] FP_ONE = 32'h0100_0000;
  localparam logic signed [VEC_W-1:0] Q_MAX  = 32'sh7FFF_FFFF;
  localparam logic signed [VEC_W-1:0] Q_MIN  = 32'sh8000_0000;
  localparam logic        [VEC_W-1:0] UQ_MAX = 32'hFFFF_FFFF;

  typedef struct packed {
    logic signed [VEC_W-1:0] x;
    logic signed [VEC_W-1:0] y;
    logic signed [VEC_W-1:0] z;
  } vec3_t;

  typedef enum logic [2:0] {
    IDLE,
    SQ,
    ISSUE,
    WAIT,
    SCALE,
    DONE
  } state_e;

endpackage

// File: rtl/q_mul_sat.sv
// rtl/q_mul_sat.sv - combinational signed fixed-point multiply, arithmetic >>> SHIFT, optional saturation
module q_mul_sat
  import vector_pkg::*;
#(
  parameter int WIDTH  = VEC_W,
  parameter int SHIFT  = FRAC,
  parameter bit SAT_EN = 1'b1
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH:0]   b,
  output logic signed [WIDTH-1:0] y
);

  localparam int PW = 2 * WIDTH + 1;
  localparam logic signed [WIDTH-1:0] SAT_HI = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SAT_LO = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [PW-1:0]    prod;
  logic signed [PW-1:0]    shifted;
  logic        [PW-WIDTH:0] hi_bits;
  logic                    ovf;
  logic                    unused_frac;

  always_comb begin
    prod    = {{(WIDTH+1){a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH]}}, b};
    shifted = prod >>> SHIFT;
    // result fits only if every bit from the WIDTH-1 sign position upward agrees
    hi_bits = shifted[PW-1:WIDTH-1];
    ovf     = !((&hi_bits) || (~|hi_bits));
    if (SAT_EN && ovf) begin
      y = hi_bits[PW-WIDTH] ? SAT_LO : SAT_HI;
    end else begin
      y = shifted[WIDTH-1:0];
    end
  end

  assign unused_frac = ^prod[SHIFT-1:0];

endmodule

// File: rtl/vec3_normalize.sv
// rtl/vec3_normalize.sv - Q8.24 3-vector normaliser using an external inverse-sqrt unit
module vec3_normalize
  import vector_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit SAT_EN = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_x,
  input  logic signed [WIDTH-1:0] in_y,
  input  logic signed [WIDTH-1:0] in_z,
  output logic                    isq_valid,
  output logic        [WIDTH-1:0] isq_x,
  input  logic                    isq_valid_out,
  input  logic        [WIDTH-1:0] isq_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_x,
  output logic signed [WIDTH-1:0] out_y,
  output logic signed [WIDTH-1:0] out_z,
  output logic                    out_zero
);

  state_e                  state_q, state_d;
  logic        [1:0]       cnt_q, cnt_d;
  vec3_t                   vec_q, vec_d;
  logic        [WIDTH+1:0] acc_q, acc_d, acc_sum;
  logic        [WIDTH-1:0] inv_q, inv_d;
  logic        [WIDTH-1:0] isq_x_q, isq_x_d;
  logic signed [WIDTH-1:0] out_x_q, out_x_d;
  logic signed [WIDTH-1:0] out_y_q, out_y_d;
  logic signed [WIDTH-1:0] out_z_q, out_z_d;
  logic                    out_zero_q, out_zero_d;

  logic signed [WIDTH-1:0] mul_a, mul_y;
  logic signed [WIDTH:0]   mul_b;

  // one multiplier: SQ squares the selected component, SCALE multiplies it by the unsigned inv
  always_comb begin
    case (cnt_q)
      2'd0:    mul_a = vec_q.x;
      2'd1:    mul_a = vec_q.y;
      default: mul_a = vec_q.z;
    endcase
    if (state_q == SCALE) begin
      mul_b = {1'b0, inv_q};
    end else begin
      mul_b = {mul_a[WIDTH-1], mul_a};
    end
  end

  q_mul_sat #(
    .WIDTH (WIDTH),
    .SHIFT (FRAC),
    .SAT_EN(SAT_EN)
  ) u_mul (
    .a(mul_a),
    .b(mul_b),
    .y(mul_y)
  );

  // squared terms are never negative, so the product is zero-extended into the accumulator
  assign acc_sum = acc_q + {2'b00, mul_y};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    vec_d      = vec_q;
    acc_d      = acc_q;
    inv_d      = inv_q;
    isq_x_d    = isq_x_q;
    out_x_d    = out_x_q;
    out_y_d    = out_y_q;
    out_z_d    = out_z_q;
    out_zero_d = out_zero_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          vec_d.x    = in_x;
          vec_d.y    = in_y;
          vec_d.z    = in_z;
          acc_d      = '0;
          cnt_d      = 2'd0;
          out_zero_d = 1'b0;
          state_d    = SQ;
        end
      end
      SQ: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd2) begin
          cnt_d = 2'd0;
          if (acc_sum == '0) begin
            out_x_d    = '0;
            out_y_d    = '0;
            out_z_d    = '0;
            out_zero_d = 1'b1;
            state_d    = DONE;
          end else begin
            if (SAT_EN && (|acc_sum[WIDTH+1:WIDTH])) begin
              isq_x_d = '1;
            end else begin
              isq_x_d = acc_sum[WIDTH-1:0];
            end
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (isq_valid_out) begin
          inv_d   = isq_result;
          state_d = SCALE;
        end
      end
      SCALE: begin
        case (cnt_q)
          2'd0:    out_x_d = mul_y;
          2'd1:    out_y_d = mul_y;
          default: out_z_d = mul_y;
        endcase
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd2) begin
          cnt_d   = 2'd0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      vec_q      <= '0;
      acc_q      <= '0;
      inv_q      <= '0;
      isq_x_q    <= '0;
      out_x_q    <= '0;
      out_y_q    <= '0;
      out_z_q    <= '0;
      out_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      vec_q      <= vec_d;
      acc_q      <= acc_d;
      inv_q      <= inv_d;
      isq_x_q    <= isq_x_d;
      out_x_q    <= out_x_d;
      out_y_q    <= out_y_d;
      out_z_q    <= out_z_d;
      out_zero_q <= out_zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign isq_valid = (state_q == ISSUE);
  assign out_valid = (state_q == DONE);
  assign isq_x     = isq_x_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign out_z     = out_z_q;
  assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_vec3_normalize.sv
// tb/tb_vec3_normalize.sv - self-checking bench for vec3_normalize with an inverse-sqrt stub
module tb_vec3_normalize;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x, in_y, in_z;
  logic        isq_valid;
  logic [31:0] isq_x;
  logic        isq_valid_out;
  logic [31:0] isq_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_x, out_y, out_z;
  logic        out_zero;

  int total = 0;
  int bad   = 0;
  int lat   = 3;
  logic [31:0] stub_val = 32'h0;
  int stub_pulses = 0;
  int n_acc = 0;

  vec3_normalize #(.WIDTH(32), .SAT_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_z(in_z),
    .isq_valid(isq_valid), .isq_x(isq_x),
    .isq_valid_out(isq_valid_out), .isq_result(isq_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_z(out_z),
    .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (!rst && in_valid && in_ready) n_acc++;

  // inverse-sqrt stub: answers each request after lat cycles with stub_val
  initial begin
    isq_valid_out = 1'b0;
    isq_result    = '0;
    forever begin
      @(negedge clk);
      if (isq_valid) begin
        repeat (lat) @(negedge clk);
        isq_valid_out = 1'b1;
        isq_result    = stub_val;
        @(negedge clk);
        isq_valid_out = 1'b0;
        isq_result    = '0;
        stub_pulses++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic longint clamp_s32(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  // reference: squared length from Q8.24 reals, then component * inv, all in 64-bit arithmetic
  function automatic void model(input logic [31:0] x, y, z, inv,
                                output logic [31:0] e_isq, e_x, e_y, e_z,
                                output logic e_zero);
    longint c[3];
    longint sum, inv_l, r;
    logic [31:0] o[3];
    c[0] = longint'($signed(x));
    c[1] = longint'($signed(y));
    c[2] = longint'($signed(z));
    inv_l = longint'(inv);
    sum = 0;
    for (int i = 0; i < 3; i++) sum += clamp_s32((c[i] * c[i]) >>> 24);
    e_zero = (sum == 0);
    e_isq  = (sum > 64'sd4294967295) ? 32'hFFFF_FFFF : sum[31:0];
    for (int i = 0; i < 3; i++) begin
      r = clamp_s32((c[i] * inv_l) >>> 24);
      o[i] = e_zero ? 32'h0 : r[31:0];
    end
    e_x = o[0];
    e_y = o[1];
    e_z = o[2];
  endfunction

  task automatic run_vec(input string tag, input logic [31:0] x, y, z, inv,
                         input int l, input int hold,
                         input logic [31:0] e_isq, e_x, e_y, e_z, input logic e_zero);
    int n, npulse;
    bit busy_ok, stable_ok, seen;
    logic [31:0] got_isq, cx, cy, cz;
    logic cz0;
    stub_val  = inv;
    lat       = l;
    out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    in_valid = 1'b1; in_x = x; in_y = y; in_z = z;
    @(negedge clk);
    in_valid = 1'b0;
    npulse = 0; busy_ok = 1'b1; seen = 1'b0; got_isq = '0; n = 1;
    while (n < 300) begin
      if (isq_valid) begin npulse++; got_isq = isq_x; end
      if (in_ready) busy_ok = 1'b0;
      if (out_valid) begin seen = 1'b1; break; end
      @(negedge clk);
      n++;
    end
    chk({tag, ".out_valid_seen"}, 32'(seen), 32'd1);
    if (!seen) return;
    chk({tag, ".latency"}, n, e_zero ? 32'd4 : 32'(8 + l));
    chk({tag, ".isq_pulses"}, npulse, e_zero ? 32'd0 : 32'd1);
    if (!e_zero) chk({tag, ".isq_x"}, got_isq, e_isq);
    chk({tag, ".in_ready_busy"}, 32'(busy_ok), 32'd1);
    chk({tag, ".out_x"}, out_x, e_x);
    chk({tag, ".out_y"}, out_y, e_y);
    chk({tag, ".out_z"}, out_z, e_z);
    chk({tag, ".out_zero"}, 32'(out_zero), 32'(e_zero));
    cx = out_x; cy = out_y; cz = out_z; cz0 = out_zero; stable_ok = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (!out_valid || in_ready || out_x !== cx || out_y !== cy || out_z !== cz || out_zero !== cz0)
        stable_ok = 1'b0;
    end
    if (hold > 0) chk({tag, ".hold_stable"}, 32'(stable_ok), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".out_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, ".in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  typedef struct {
    logic [31:0] x, y, z, inv;
    int lat, hold;
    logic [31:0] e_isq, e_x, e_y, e_z;
    logic e_zero;
  } vec_rec_t;

  vec_rec_t tbl[6];

  initial begin
    logic [31:0] rx, ry, rz, rinv, eisq, ex, ey, ez;
    logic ezero;
    int n, p0, acc0, n_vec;
    bit ov;

    tbl[0] = '{32'h0100_0000, 32'h0, 32'h0, 32'h0100_0000, 3, 0,
               32'h0100_0000, 32'h0100_0000, 32'h0, 32'h0, 1'b0};
    tbl[1] = '{32'h0300_0000, 32'h0400_0000, 32'h0, 32'h0033_3333, 1, 5,
               32'h1900_0000, 32'h0099_9999, 32'h00CC_CCCC, 32'h0, 1'b0};
    tbl[2] = '{32'h0, 32'h0, 32'h0, 32'h0100_0000, 3, 2,
               32'h0, 32'h0, 32'h0, 32'h0, 1'b1};
    tbl[3] = '{32'h6400_0000, 32'h6400_0000, 32'h6400_0000, 32'h0010_0000, 20, 5,
               32'hFFFF_FFFF, 32'h0640_0000, 32'h0640_0000, 32'h0640_0000, 1'b0};
    tbl[4] = '{32'hFD00_0000, 32'hFC00_0000, 32'h0, 32'h0033_3333, 3, 0,
               32'h1900_0000, 32'hFF66_6667, 32'hFF33_3334, 32'h0, 1'b0};
    tbl[5] = '{32'h7F00_0000, 32'h8100_0000, 32'h0, 32'h0200_0000, 2, 1,
               32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_z = '0; out_ready = 1'b0;
    n_vec = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk("reset.isq_valid", 32'(isq_valid), 32'd0);
    chk("reset.isq_x", isq_x, 32'd0);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.out_x", out_x, 32'd0);
    chk("reset.out_zero", 32'(out_zero), 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_vec($sformatf("tbl%0d", i), tbl[i].x, tbl[i].y, tbl[i].z, tbl[i].inv,
              tbl[i].lat, tbl[i].hold, tbl[i].e_isq, tbl[i].e_x, tbl[i].e_y,
              tbl[i].e_z, tbl[i].e_zero);
      n_vec++;
    end

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: begin
          rx = $urandom_range(0, 32'h0800_0000);
          ry = $urandom_range(0, 32'h0800_0000);
          rz = $urandom_range(0, 32'h0800_0000);
        end
        1: begin rx = $urandom; ry = $urandom; rz = $urandom; end
        default: begin
          rx = $urandom_range(0, 32'h0FFF);
          ry = $urandom_range(0, 32'h0FFF);
          rz = $urandom_range(0, 32'h0FFF);
        end
      endcase
      if ($urandom_range(0, 1) == 1) rx = -rx;
      if ($urandom_range(0, 1) == 1) ry = -ry;
      if ($urandom_range(0, 1) == 1) rz = -rz;
      rinv = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 32'h0200_0000);
      model(rx, ry, rz, rinv, eisq, ex, ey, ez, ezero);
      run_vec($sformatf("rnd%0d", i), rx, ry, rz, rinv, $urandom_range(1, 6),
              $urandom_range(0, 2), eisq, ex, ey, ez, ezero);
      n_vec++;
    end

    // reset while waiting on the inverse-sqrt unit; its late answer must be ignored
    lat = 20; stub_val = 32'h0033_3333;
    in_valid = 1'b1; in_x = 32'h0300_0000; in_y = 32'h0400_0000; in_z = 32'h0;
    @(negedge clk);
    in_valid = 1'b0;
    n_vec++;
    n = 0;
    while (!isq_valid && n < 50) begin @(negedge clk); n++; end
    chk("rst_wait.isq_seen", 32'(isq_valid), 32'd1);
    repeat (3) @(negedge clk);
    p0 = stub_pulses;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_wait.in_ready", 32'(in_ready), 32'd1);
    chk("rst_wait.isq_valid", 32'(isq_valid), 32'd0);
    chk("rst_wait.isq_x", isq_x, 32'd0);
    chk("rst_wait.out_valid", 32'(out_valid), 32'd0);
    chk("rst_wait.out_x", out_x, 32'd0);
    chk("rst_wait.out_zero", 32'(out_zero), 32'd0);
    ov = 1'b0;
    repeat (30) begin @(negedge clk); if (out_valid || !in_ready) ov = 1'b1; end
    chk("rst_wait.stale_delivered", stub_pulses, p0 + 1);
    chk("rst_wait.no_out_valid", 32'(ov), 32'd0);

    // reset and in_valid together: the vector must not be taken
    acc0 = n_acc;
    rst = 1'b1; in_valid = 1'b1; in_x = 32'h0100_0000; in_y = '0; in_z = '0;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    ov = 1'b0;
    repeat (12) begin @(negedge clk); if (out_valid || !in_ready) ov = 1'b1; end
    chk("rst_in_valid.ignored", 32'(ov), 32'd0);
    chk("rst_in_valid.no_accept", n_acc, acc0);

    run_vec("recover", 32'h0100_0000, 32'h0, 32'h0, 32'h0100_0000, 3, 0,
            32'h0100_0000, 32'h0100_0000, 32'h0, 32'h0, 1'b0);
    n_vec++;
    chk("accept_count", n_acc, n_vec);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
